// File: rtl/shiftreg_arbiter.sv
// rtl/shiftreg_arbiter.sv - round-robin arbiter feeding a valid-gated delay line with tagged responses
module shiftreg_arbiter #(
    parameter int NumReq    = 4,
    parameter int Depth     = 4,
    parameter int DataWidth = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_data_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic                                flush_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_data_o,
    output logic [$clog2(Depth+1)-1:0]          inflight_o,
    output logic                                busy_o
);

    localparam int TagW = $clog2(NumReq);
    localparam int CntW = $clog2(Depth+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                            state_q, state_d;
    logic [TagW-1:0]                   ptr_q, ptr_d;
    logic [CntW-1:0]                   inflight_q, inflight_d;
    logic [Depth-1:0]                  vld_q;
    logic [Depth-1:0][DataWidth-1:0]   data_q;
    logic [Depth-1:0][TagW-1:0]        tag_q;

    logic            gnt_found;
    logic [TagW-1:0] gnt_idx;
    logic [TagW-1:0] scan_idx;
    logic            can_grant;
    logic            xfer;
    logic            exit_v;

    // Scan from the pointer upward, wrapping at NumReq-1, so non-power-of-two counts work.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = ptr_q;
        for (int i = 0; i < NumReq; i++) begin
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
            scan_idx = (scan_idx == TagW'(NumReq-1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // A flush in the same cycle as a request wins over the request.
    assign can_grant = rst_ni && (state_q != DRAIN) && !flush_i;

    always_comb begin
        req_ready_o = '0;
        if (can_grant && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign xfer   = |(req_valid_i & req_ready_o);
    assign exit_v = vld_q[Depth-1];

    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = inflight_q + CntW'(xfer) - CntW'(exit_v);
        if (xfer) begin
            ptr_d = (gnt_idx == TagW'(NumReq-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i)   state_d = DRAIN;
                else if (xfer) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (flush_i)                           state_d = DRAIN;
                else if (!xfer && inflight_d == '0)    state_d = IDLE;
            end
            DRAIN: begin
                if (inflight_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Valids shift every cycle; payload and tag only move behind a valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q[0] <= xfer;
            if (xfer) begin
                data_q[0] <= req_data_i[gnt_idx];
                tag_q[0]  <= gnt_idx;
            end
            for (int k = 1; k < Depth; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (exit_v) begin
            rsp_valid_o[tag_q[Depth-1]] = 1'b1;
        end
    end

    assign rsp_data_o = data_q[Depth-1];
    assign inflight_o = inflight_q;
    assign busy_o     = (state_q != IDLE);

endmodule
